sweep_ctrl: RTL and testbench
=============================

# sweep_ctrl

Frequency-sweep scheduler for the phase-accumulator sine generator. Drives the generator's 16-bit `step` input through a programmed ramp, holding each value for a programmed dwell. Supports single-shot, sawtooth-repeat and triangle patterns, with a start/abort handshake and status pulses. Sits between the host/config registers and the sine wave NCO; its `step` output connects directly to the NCO `step` port.

## Interface

**Parameters**
- `DWELL_W`, default 16: width of the dwell counter and of `cfg_dwell`.

**Ports**
- `clk` in 1: single clock, shared with the NCO.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; latches all `cfg_*` and begins a sweep.
- `abort` in 1: one-cycle request; terminates the sweep.
- `cfg_start` in 16: first step value.
- `cfg_stop` in 16: upper bound of the ramp.
- `cfg_inc` in 16: increment per dwell period.
- `cfg_dwell` in DWELL_W: each value is held for `cfg_dwell+1` cycles.
- `cfg_mode` in 2: 00 single-up; 01 sawtooth repeat; 10 triangle continuous; 11 treated as 00.
- `step` out 16: registered tuning word to the NCO.
- `busy` out 1: high from the cycle after an accepted `start` until DONE or abort.
- `step_tick` out 1: one-cycle pulse in every cycle `step` changes value.
- `wrap` out 1: one-cycle pulse on sawtooth reload, or on triangle direction reversal.
- `done` out 1: one-cycle pulse when a single-up sweep completes.

## Operation

- **States:** IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE at end of a single-up ramp.
  - RUN → IDLE on `abort`.
  - DONE → IDLE the next cycle.
  - DONE → RUN if `start` arrives in the DONE cycle.
- **Configuration latching:** on an accepted `start`, latch all `cfg_*` into shadow registers. Changes to `cfg_*` during RUN have no effect.
- **`start` acceptance:** accepted only in IDLE or DONE. Ignored in RUN.
- **Dwell counter:** loads `cfg_dwell` on entry to RUN and on every step change. Decrements each RUN cycle. At 0, an advance occurs.
- **Advance arithmetic:** 17-bit compare, no silent 16-bit wrap.
  - Up: `nxt = step + inc`. If `nxt > stop` (including carry out), the ramp ends.
  - Down (triangle only): if `step < start + inc`, the ramp ends; otherwise `nxt = step - inc`.
- **End of ramp:**
  - Mode 00: hold `step`, go to DONE, pulse `done`.
  - Mode 01: `step <= start`, pulse `wrap` and `step_tick`.
  - Mode 10, going up: switch direction to down, pulse `wrap`. `step` stays at its current value for one further dwell (no repeated edge value beyond that).
  - Mode 10, going down: switch direction to up, pulse `wrap`, same hold rule.
- **Degenerate config:** if `cfg_inc == 0` or `cfg_start > cfg_stop`, `step` is set to `cfg_start` and the block behaves as mode 00 with an immediate end of ramp after the first dwell. `done` fires after `cfg_dwell+1` cycles.
- **Abort:** `step` holds its last value, `busy` drops, and no `done` pulse is issued.
- **`abort` priority:** `abort` wins over `start` in the same cycle. An `abort` in IDLE has no effect.
- **After completion or abort:** `step` is held, so the NCO keeps running at the final frequency until the next `start`.

## Timing

- **Reset values:**
  - `step`=0, `busy`=0, `step_tick`=0, `wrap`=0, `done`=0.
  - State = IDLE, direction = up, dwell counter = 0.
- **`start` accepted at cycle T:**
  - At T+1: `step`=`cfg_start`, `busy`=1, `step_tick`=1.
  - First advance visible at T+1+`cfg_dwell`+1.
- **Steady state:** each `step` value is present for exactly `cfg_dwell+1` cycles. With `cfg_dwell`=0, `step` changes every cycle.
- **`done`:** asserted in the cycle `busy` falls (state DONE). `step` is unchanged in that cycle.
- **`abort` at cycle T:** `busy`=0 at T+1, and no further `step` change occurs.
- **NCO latency:** the NCO sees the new `step` on the edge after `step_tick`. The frequency change is visible at `wave_out` 2 cycles later; this is an NCO property and is not compensated here.

## Configuration

- **Macro:** `SWEEP_TRIANGLE_EN`.
- **Defined:** mode 10 is triangle, with direction register and down-ramp arithmetic.
- **Undefined:** the direction register and subtractor are removed, and mode 10 behaves exactly as mode 01 (sawtooth).

## Test plan

- **Reset:** assert `reset_n`=0 mid-sweep → all outputs 0 immediately (asynchronous); state IDLE after release.
- **Single-up:** start=0x1000, stop=0x1030, inc=0x10, dwell=2, mode 00 → `step` sequence 1000,1010,1020,1030, each 3 cycles; `done` pulse 3 cycles after 1030 appears; `step` holds 0x1030.
- **Sawtooth, overflow guard:** start=0xFFF0, stop=0xFFFF, inc=0x8, dwell=0, mode 01 → FFF0,FFF8 then reload FFF0 with `wrap`; never 0x0000.
- **Triangle:** start=0x10, stop=0x30, inc=0x10, dwell=0, mode 10 → 10,20,30,30,20,10,10,20…; `wrap` on each reversal. With macro undefined → sawtooth pattern.
- **Abort/start collision:** `start` and `abort` in the same cycle during RUN → `busy` falls, `step` held, no `done`. `start` during RUN alone → ignored. `cfg_*` change during RUN → no effect.
- **Degenerate:** `cfg_inc`=0, dwell=4 → `step`=`cfg_start` for 5 cycles, then `done`.

Source files
------------

// File: rtl/sweep_ctrl.sv
// Frequency-sweep scheduler driving the NCO step word through a dwell-timed ramp (single, sawtooth, triangle).
// Optional triangle mode is enabled by `SWEEP_TRIANGLE_EN; without it mode 10 runs as sawtooth.
module sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [15:0]        cfg_start,
  input  logic [15:0]        cfg_stop,
  input  logic [15:0]        cfg_inc,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  output logic [15:0]        step,
  output logic               busy,
  output logic               step_tick,
  output logic               wrap,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;
  logic [15:0]        sh_start_q, sh_start_d;
  logic [15:0]        sh_stop_q, sh_stop_d;
  logic [15:0]        sh_inc_q, sh_inc_d;
  logic [DWELL_W-1:0] sh_dwell_q, sh_dwell_d;
  logic [1:0]         sh_mode_q, sh_mode_d;
  logic               sh_degen_q, sh_degen_d;
`ifdef SWEEP_TRIANGLE_EN
  logic               dir_dn_q, dir_dn_d;
  logic [16:0]        dn_floor;
`endif

  logic [16:0] up_nxt;
  logic        cfg_degen;
  logic [1:0]  cfg_mode_eff;

  // 17-bit sums so a ramp near 0xFFFF ends instead of wrapping to 0
  assign up_nxt    = {1'b0, step_q} + {1'b0, sh_inc_q};
`ifdef SWEEP_TRIANGLE_EN
  assign dn_floor  = {1'b0, sh_start_q} + {1'b0, sh_inc_q};
`endif
  assign cfg_degen = (cfg_inc == 16'd0) || (cfg_start > cfg_stop);

  always_comb begin
    cfg_mode_eff = cfg_mode;
    if (cfg_mode == 2'b11 || cfg_degen) cfg_mode_eff = 2'b00;
`ifndef SWEEP_TRIANGLE_EN
    if (cfg_mode_eff == 2'b10) cfg_mode_eff = 2'b01;
`endif
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    dwell_d    = dwell_q;
    tick_d     = 1'b0;
    wrap_d     = 1'b0;
    sh_start_d = sh_start_q;
    sh_stop_d  = sh_stop_q;
    sh_inc_d   = sh_inc_q;
    sh_dwell_d = sh_dwell_q;
    sh_mode_d  = sh_mode_q;
    sh_degen_d = sh_degen_q;
`ifdef SWEEP_TRIANGLE_EN
    dir_dn_d   = dir_dn_q;
`endif
    case (state_q)
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (dwell_q != '0) begin
          dwell_d = dwell_q - DWELL_W'(1);
        end else begin
          dwell_d = sh_dwell_q;
`ifdef SWEEP_TRIANGLE_EN
          if (sh_mode_q == 2'b10 && dir_dn_q) begin
            if ({1'b0, step_q} < dn_floor) begin
              dir_dn_d = 1'b0;
              wrap_d   = 1'b1;
            end else begin
              step_d = step_q - sh_inc_q;
              tick_d = 1'b1;
            end
          end else
`endif
          if (sh_degen_q || up_nxt > {1'b0, sh_stop_q}) begin
            case (sh_mode_q)
              2'b01: begin
                step_d = sh_start_q;
                tick_d = 1'b1;
                wrap_d = 1'b1;
              end
`ifdef SWEEP_TRIANGLE_EN
              2'b10: begin
                dir_dn_d = 1'b1;
                wrap_d   = 1'b1;
              end
`endif
              default: state_d = S_DONE;
            endcase
          end else begin
            step_d = up_nxt[15:0];
            tick_d = 1'b1;
          end
        end
      end
      default: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        // abort outranks a coincident start
        if (start && !abort) begin
          state_d    = S_RUN;
          step_d     = cfg_start;
          dwell_d    = cfg_dwell;
          tick_d     = 1'b1;
          sh_start_d = cfg_start;
          sh_stop_d  = cfg_stop;
          sh_inc_d   = cfg_inc;
          sh_dwell_d = cfg_dwell;
          sh_mode_d  = cfg_mode_eff;
          sh_degen_d = cfg_degen;
`ifdef SWEEP_TRIANGLE_EN
          dir_dn_d   = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      dwell_q    <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      sh_start_q <= '0;
      sh_stop_q  <= '0;
      sh_inc_q   <= '0;
      sh_dwell_q <= '0;
      sh_mode_q  <= '0;
      sh_degen_q <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
      dir_dn_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      dwell_q    <= dwell_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      sh_start_q <= sh_start_d;
      sh_stop_q  <= sh_stop_d;
      sh_inc_q   <= sh_inc_d;
      sh_dwell_q <= sh_dwell_d;
      sh_mode_q  <= sh_mode_d;
      sh_degen_q <= sh_degen_d;
`ifdef SWEEP_TRIANGLE_EN
      dir_dn_q   <= dir_dn_d;
`endif
    end
  end

  assign step      = step_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign step_tick = tick_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed self-checking bench for sweep_ctrl: reset, single-up, sawtooth, triangle, collisions, degenerate, back-to-back.
module tb_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_start = '0;
  logic [15:0] cfg_stop = '0;
  logic [15:0] cfg_inc = '0;
  logic [15:0] cfg_dwell = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] step;
  logic        busy, step_tick, wrap, done;

  int tests = 0;
  int fails = 0;

  sweep_ctrl #(.DWELL_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_inc(cfg_inc),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
    .step(step), .busy(busy), .step_tick(step_tick), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle; returns in cycle T+1.
  task automatic do_start(input logic [15:0] s, input logic [15:0] e, input logic [15:0] inc,
                          input logic [15:0] dw, input logic [1:0] md);
    cfg_start = s; cfg_stop = e; cfg_inc = inc; cfg_dwell = dw; cfg_mode = md;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    tests++;
    if ({step, busy, step_tick, wrap, done} !== 20'h0) begin
      fails++; $display("FAIL reset_init: got %h expected 0", {step, busy, step_tick, wrap, done});
    end
    cyc(); reset_n = 1'b1; cyc();
    do_start(16'h0100, 16'h0200, 16'h0010, 16'd0, 2'b00);
    cyc(); cyc();
    tests++;
    if (step !== 16'h0120 || busy !== 1'b1) begin
      fails++; $display("FAIL reset_presweep: got step %h busy %b expected 0120 1", step, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({step, busy, step_tick, wrap, done} !== 20'h0) begin
      fails++; $display("FAIL reset_async: got %h expected 0", {step, busy, step_tick, wrap, done});
    end
    cyc(); reset_n = 1'b1; cyc(); cyc();
    tests++;
    if (step !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_idle: got step %h busy %b done %b expected 0 0 0", step, busy, done);
    end
  endtask

  task automatic test_single();
    logic [15:0] exp;
    do_start(16'h1000, 16'h1030, 16'h0010, 16'd2, 2'b00);
    for (int i = 0; i < 12; i++) begin
      exp = 16'h1000 + 16'(16'h10 * (i / 3));
      tests++;
      if (step !== exp || busy !== 1'b1 || done !== 1'b0 || step_tick !== (i % 3 == 0)) begin
        fails++;
        $display("FAIL single[%0d]: got step %h busy %b done %b tick %b expected %h 1 0 %b",
                 i, step, busy, done, step_tick, exp, (i % 3 == 0));
      end
      cyc();
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || step !== 16'h1030) begin
      fails++; $display("FAIL single_done: got done %b busy %b step %h expected 1 0 1030", done, busy, step);
    end
    cyc();
    tests++;
    if (done !== 1'b0 || step !== 16'h1030) begin
      fails++; $display("FAIL single_hold: got done %b step %h expected 0 1030", done, step);
    end
  endtask

  task automatic test_sawtooth();
    logic [15:0] exp;
    do_start(16'hFFF0, 16'hFFFF, 16'h0008, 16'd0, 2'b01);
    for (int i = 0; i < 6; i++) begin
      exp = (i % 2 == 0) ? 16'hFFF0 : 16'hFFF8;
      tests++;
      if (step !== exp || step_tick !== 1'b1 || wrap !== (i > 0 && i % 2 == 0)) begin
        fails++;
        $display("FAIL saw[%0d]: got step %h tick %b wrap %b expected %h 1 %b",
                 i, step, step_tick, wrap, exp, (i > 0 && i % 2 == 0));
      end
      cyc();
    end
    abort = 1'b1; cyc(); abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (step !== 16'hFFF0 || busy !== 1'b0 || done !== 1'b0 || step_tick !== 1'b0) begin
        fails++;
        $display("FAIL saw_abort[%0d]: got step %h busy %b done %b tick %b expected FFF0 0 0 0",
                 i, step, busy, done, step_tick);
      end
      cyc();
    end
  endtask

  task automatic test_triangle();
    logic [15:0] seq [10];
    logic        tk [10];
    logic        wr [10];
`ifdef SWEEP_TRIANGLE_EN
    seq = '{16'h10, 16'h20, 16'h30, 16'h30, 16'h20, 16'h10, 16'h10, 16'h20, 16'h30, 16'h30};
    tk  = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 0};
`else
    seq = '{16'h10, 16'h20, 16'h30, 16'h10, 16'h20, 16'h30, 16'h10, 16'h20, 16'h30, 16'h10};
    tk  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
    wr  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    do_start(16'h0010, 16'h0030, 16'h0010, 16'd0, 2'b10);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (step !== seq[i] || step_tick !== tk[i] || wrap !== wr[i] || busy !== 1'b1) begin
        fails++;
        $display("FAIL tri[%0d]: got step %h tick %b wrap %b busy %b expected %h %b %b 1",
                 i, step, step_tick, wrap, busy, seq[i], tk[i], wr[i]);
      end
      cyc();
    end
    abort = 1'b1; cyc(); abort = 1'b0; cyc();
  endtask

  task automatic test_collision();
    do_start(16'h0100, 16'h0200, 16'h0010, 16'd1, 2'b00);
    cyc();
    cfg_start = 16'h0500; cfg_stop = 16'h0600; cfg_inc = 16'h0040; cfg_dwell = 16'd0; cfg_mode = 2'b01;
    start = 1'b1; cyc(); start = 1'b0;
    tests++;
    if (step !== 16'h0110 || busy !== 1'b1) begin
      fails++; $display("FAIL coll_ignore_start: got step %h busy %b expected 0110 1", step, busy);
    end
    cyc(); cyc();
    tests++;
    if (step !== 16'h0120 || busy !== 1'b1) begin
      fails++; $display("FAIL coll_cfg_shadow: got step %h busy %b expected 0120 1", step, busy);
    end
    start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (step !== 16'h0120 || busy !== 1'b0 || done !== 1'b0 || step_tick !== 1'b0) begin
        fails++;
        $display("FAIL coll_abort[%0d]: got step %h busy %b done %b tick %b expected 0120 0 0 0",
                 i, step, busy, done, step_tick);
      end
      cyc();
    end
  endtask

  task automatic test_degenerate();
    do_start(16'h0777, 16'h1000, 16'h0000, 16'd4, 2'b01);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (step !== 16'h0777 || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL degen_inc0[%0d]: got step %h busy %b done %b expected 0777 1 0", i, step, busy, done);
      end
      cyc();
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || step !== 16'h0777) begin
      fails++; $display("FAIL degen_inc0_done: got done %b busy %b step %h expected 1 0 0777", done, busy, step);
    end
    cyc(); cyc();
    do_start(16'h2000, 16'h1000, 16'h0005, 16'd0, 2'b01);
    tests++;
    if (step !== 16'h2000 || busy !== 1'b1) begin
      fails++; $display("FAIL degen_order_first: got step %h busy %b expected 2000 1", step, busy);
    end
    cyc();
    tests++;
    if (done !== 1'b1 || step !== 16'h2000) begin
      fails++; $display("FAIL degen_order_done: got done %b step %h expected 1 2000", done, step);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    do_start(16'h0040, 16'h0040, 16'h0001, 16'd0, 2'b00);
    tests++;
    if (step !== 16'h0040 || busy !== 1'b1) begin
      fails++; $display("FAIL b2b_first: got step %h busy %b expected 0040 1", step, busy);
    end
    cyc();
    tests++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL b2b_done1: got done %b expected 1", done);
    end
    do_start(16'h0080, 16'h0081, 16'h0001, 16'd0, 2'b11);
    tests++;
    if (step !== 16'h0080 || busy !== 1'b1 || step_tick !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_restart: got step %h busy %b tick %b done %b expected 0080 1 1 0",
               step, busy, step_tick, done);
    end
    cyc();
    tests++;
    if (step !== 16'h0081 || busy !== 1'b1) begin
      fails++; $display("FAIL b2b_step2: got step %h busy %b expected 0081 1", step, busy);
    end
    cyc();
    tests++;
    if (done !== 1'b1 || wrap !== 1'b0 || step !== 16'h0081) begin
      fails++; $display("FAIL b2b_mode11_done: got done %b wrap %b step %h expected 1 0 0081", done, wrap, step);
    end
    cyc();
    abort = 1'b1; cyc(); abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || step !== 16'h0081 || done !== 1'b0) begin
      fails++; $display("FAIL idle_abort: got busy %b step %h done %b expected 0 0081 0", busy, step, done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sawtooth();
    test_triangle();
    test_collision();
    test_degenerate();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
